tt_memop_req_arb: RTL and testbench
===================================

Name: tt_memop_req_arb

Overview:
- Sequences one vector memop's memory-request phase between the memop FSM and the OVI memory port.
- Arbitrates the load-address stream and the store-address/data stream onto a single request port.
- Tracks outstanding requests against a credit limit.
- Produces the busy indication and sync-end pulse that the memop FSM consumes (its mem_req and memop_sync_end inputs).

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, store data width
- MAX_OUTST, 8, maximum in-flight requests (credits); must be ≥1
- TAG_W, 3, request tag width; 2^TAG_W ≥ MAX_OUTST
- TIMEOUT_CYC, 1024, drain watchdog limit (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_sync_start  in  1  memop accepted by memop FSM (one-cycle pulse)
- i_is_load  in  1  memop type, sampled with i_sync_start
- i_issue_done  in  1  last uop of the memop issued; no further requests will arrive
- i_ld_valid  in  1  load request valid
- i_ld_addr  in  ADDR_W  load address
- o_ld_ready  out  1  load request accepted
- i_st_valid  in  1  store request valid
- i_st_addr  in  ADDR_W  store address
- i_st_data  in  DATA_W  store data
- o_st_ready  out  1  store request accepted
- o_mem_valid  out  1  memory request valid
- o_mem_we  out  1  1 = store
- o_mem_addr  out  ADDR_W  request address
- o_mem_data  out  DATA_W  store data (0 for loads)
- o_mem_tag  out  TAG_W  request tag
- i_mem_ready  in  1  memory port accepts request
- i_resp_valid  in  1  response or ack returned
- o_mem_req  out  1  requests pending or in flight
- o_sync_end  out  1  memop request phase complete (one-cycle pulse)
- o_outst  out  $clog2(MAX_OUTST+1)  in-flight count
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE; o_outst=0; tag=0; o_err=0; RR pointer → load. All outputs 0, including readies and o_mem_valid.
- Reset mid-operation drops all in-flight state immediately. Responses arriving after reset are treated as spurious.
- State machine:
  - IDLE → ACTIVE on i_sync_start. Latch i_is_load.
  - ACTIVE → DRAIN on i_issue_done when no request is held in the output register.
  - DRAIN → END when o_outst==0 and no response arrives this cycle.
  - END → IDLE unconditionally. o_sync_end=1 only in END.
- Output register (1 deep):
  - Holds the arbitration winner. o_mem_valid stays high until i_mem_ready.
  - Fields stay stable while valid && !ready.
- Arbitration: round-robin between load and store.
  - Winner's ready=1 only when: state ACTIVE, output register empty or draining this cycle, and (o_outst + held) < MAX_OUTST.
  - RR pointer flips after each grant.
  - A valid request on the side that mismatches the latched type sets o_err but is still served.
- Counting:
  - o_outst +1 on (o_mem_valid && i_mem_ready); −1 on i_resp_valid.
  - Both in the same cycle: count unchanged.
  - i_resp_valid with o_outst==0: set o_err; count saturates at 0.
- Tag increments mod 2^TAG_W per accepted request. It is not reset between memops.
- o_mem_req = state≠IDLE && (o_mem_valid || o_outst≠0 || state==ACTIVE).
- i_sync_start while not IDLE: ignored, sets o_err.
- i_issue_done in IDLE or DRAIN: ignored.
- Latency:
  - Request accept → o_mem_valid: 1 cycle.
  - Last response → o_sync_end: 1 cycle (DRAIN→END).
  - With no requests at all: start → end minimum 3 cycles.

Optional Feature:
- Macro: TT_MEMOP_ARB_TIMEOUT_EN.
- With the macro:
  - Watchdog counter resets on every response or state entry.
  - In DRAIN, reaching TIMEOUT_CYC cycles without a response sets o_err, clears o_outst, and forces END.
- Without the macro: no counter is built, and DRAIN waits indefinitely.

Decomposition:
- Package tt_memop_arb_pkg:
  - State enum arb_state_t {IDLE, ACTIVE, DRAIN, END} as logic[1:0].
  - Request struct {we, addr, data, tag}.
- Sub-module tt_rr_arb2: 2-requester round-robin arbiter with grant and pointer update, reusable elsewhere.

Test Plan:
- Single load: start(is_load=1), 3 loads with i_mem_ready=1, issue_done, responses 5 cycles later → 3 requests with tags 0,1,2 and o_outst peaks at 3. o_sync_end pulses exactly 1 cycle after the 3rd response, then returns to IDLE.
- Credit limit: MAX_OUTST=8, 12 stores, responses withheld → 8 accepted, then o_st_ready=0. Each response admits exactly one more request.
- Backpressure: i_mem_ready=0 for 4 cycles → o_mem_addr, o_mem_data and o_mem_tag stay stable; no further requests are accepted.
- Simultaneous accept and response at o_outst=5 → o_outst stays 5. Spurious response in IDLE → o_err=1 and the count stays 0.
- Both ld and st valid every cycle → grants alternate ld, st, ld, st, and o_err sets on the first mismatched grant.
- Reset at o_outst=4 in DRAIN → next cycle IDLE with o_outst=0 and no o_sync_end. With TT_MEMOP_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, a withheld response gives o_err=1 and o_sync_end after 16 cycles.

Source files
------------

// File: rtl/tt_memop_arb_pkg.sv
// Shared types for the memop request arbiter: FSM state encoding and the
// request record held in the one-deep output register.
package tt_memop_arb_pkg;

  // Field widths of the held request; instances may use narrower ports.
  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 64;
  localparam int REQ_TAG_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    END    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
    logic [REQ_TAG_W-1:0]  tag;
  } mem_req_t;

endpackage

// File: rtl/tt_rr_arb2.sv
// Two-requester round-robin arbiter: pointer 0 prefers requester 0, and the
// pointer flips whenever the caller reports that a grant was taken.
module tt_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic ptr_q;

  always_comb begin
    o_gnt = 2'b00;
    if (!ptr_q) begin
      if (i_req[0])      o_gnt = 2'b01;
      else if (i_req[1]) o_gnt = 2'b10;
    end else begin
      if (i_req[1])      o_gnt = 2'b10;
      else if (i_req[0]) o_gnt = 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)        ptr_q <= 1'b0;
    else if (i_advance) ptr_q <= ~ptr_q;
  end

endmodule

// File: rtl/tt_memop_req_arb.sv
// Memory-request phase sequencer for one vector memop: arbitrates load and
// store streams, tracks credits, and reports busy / sync-end.
// Optional drain watchdog: define TT_MEMOP_ARB_TIMEOUT_EN.
module tt_memop_req_arb
  import tt_memop_arb_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MAX_OUTST   = 8,
  parameter int TAG_W       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_sync_start,
  input  logic                           i_is_load,
  input  logic                           i_issue_done,
  input  logic                           i_ld_valid,
  input  logic [ADDR_W-1:0]              i_ld_addr,
  output logic                           o_ld_ready,
  input  logic                           i_st_valid,
  input  logic [ADDR_W-1:0]              i_st_addr,
  input  logic [DATA_W-1:0]              i_st_data,
  output logic                           o_st_ready,
  output logic                           o_mem_valid,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [DATA_W-1:0]              o_mem_data,
  output logic [TAG_W-1:0]               o_mem_tag,
  input  logic                           i_mem_ready,
  input  logic                           i_resp_valid,
  output logic                           o_mem_req,
  output logic                           o_sync_end,
  output logic [$clog2(MAX_OUTST+1)-1:0] o_outst,
  output logic                           o_err,
  output arb_state_t                     o_state
);

  localparam int OUT_W = $clog2(MAX_OUTST+1);
  localparam logic [OUT_W:0] CRED_LIM = (OUT_W+1)'(MAX_OUTST);

  if (MAX_OUTST < 1 || (1 << TAG_W) < MAX_OUTST) begin : g_bad_credit
    $error("MAX_OUTST must be >= 1 and fit in the tag space");
  end
  if (ADDR_W > REQ_ADDR_W || DATA_W > REQ_DATA_W || TAG_W > REQ_TAG_W || TIMEOUT_CYC < 1) begin : g_bad_width
    $error("port widths exceed mem_req_t fields or TIMEOUT_CYC < 1");
  end

  arb_state_t       state_q, state_d;
  logic             is_load_q, done_q, err_q, out_vld_q;
  logic [OUT_W-1:0] outst_q;
  logic [TAG_W-1:0] tag_q;
  mem_req_t         out_q;
  logic [1:0]       gnt;
  logic             slot_free, credit_ok, can_accept;
  logic             ld_fire, st_fire, acc, mem_fire;
  logic             resp_ok, spurious, mismatch, timeout;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Upstream valid must not depend on ready; ready here may depend on valid
  // (only the arbitration winner is offered ready).
  assign slot_free  = !out_vld_q || i_mem_ready;
  assign credit_ok  = ({1'b0, outst_q} + {{OUT_W{1'b0}}, out_vld_q}) < CRED_LIM;
  assign can_accept = (state_q == ACTIVE) && slot_free && credit_ok;
  assign o_ld_ready = gnt[0] && can_accept;
  assign o_st_ready = gnt[1] && can_accept;
  assign ld_fire    = i_ld_valid && o_ld_ready;
  assign st_fire    = i_st_valid && o_st_ready;
  assign acc        = ld_fire || st_fire;
  assign mem_fire   = out_vld_q && i_mem_ready;
  assign resp_ok    = i_resp_valid && (outst_q != '0);
  assign spurious   = i_resp_valid && (outst_q == '0);
  assign mismatch   = (st_fire && is_load_q) || (ld_fire && !is_load_q);

  tt_rr_arb2 u_rr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     ({i_st_valid, i_ld_valid}),
    .i_advance (acc),
    .o_gnt     (gnt)
  );

`ifdef TT_MEMOP_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC+1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_resp_valid || (state_d != state_q)) wd_q <= '0;
    else if (state_q == DRAIN)                           wd_q <= wd_q + WD_W'(1);
  end

  assign timeout = (state_q == DRAIN) && !i_resp_valid && (outst_q != '0) &&
                   (wd_q == WD_W'(TIMEOUT_CYC-1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_sync_start) state_d = ACTIVE;
      ACTIVE:  if ((i_issue_done || done_q) && !out_vld_q && !acc) state_d = DRAIN;
      DRAIN:   if (((outst_q == '0) && !i_resp_valid) || timeout) state_d = END;
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tag_q     <= '0;
      outst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_sync_start) is_load_q <= i_is_load;
      // Remember issue_done while the output register still holds a request.
      done_q <= (state_q == ACTIVE) && (state_d == ACTIVE) && (done_q || i_issue_done);
      err_q  <= err_q || spurious || mismatch || timeout ||
                (i_sync_start && state_q != IDLE);
      if (acc) tag_q <= tag_q + TAG_W'(1);
      if (timeout)                 outst_q <= '0;
      else if (mem_fire && !resp_ok) outst_q <= outst_q + OUT_W'(1);
      else if (!mem_fire && resp_ok) outst_q <= outst_q - OUT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (acc) begin
      out_vld_q  <= 1'b1;
      out_q.we   <= st_fire;
      out_q.addr <= st_fire ? REQ_ADDR_W'(i_st_addr) : REQ_ADDR_W'(i_ld_addr);
      out_q.data <= st_fire ? REQ_DATA_W'(i_st_data) : '0;
      out_q.tag  <= REQ_TAG_W'(tag_q);
    end else if (mem_fire) begin
      out_vld_q <= 1'b0;
    end
  end

  assign o_mem_valid = out_vld_q;
  assign o_mem_we    = out_q.we;
  assign o_mem_addr  = out_q.addr[ADDR_W-1:0];
  assign o_mem_data  = out_q.data[DATA_W-1:0];
  assign o_mem_tag   = out_q.tag[TAG_W-1:0];
  assign o_mem_req   = (state_q != IDLE) &&
                       (out_vld_q || (outst_q != '0) || (state_q == ACTIVE));
  assign o_sync_end  = (state_q == END);
  assign o_outst     = outst_q;
  assign o_err       = err_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_tt_memop_req_arb.sv
// Self-checking bench for tt_memop_req_arb: scoreboard of accepted requests
// against the memory port, plus directed credit/backpressure/FSM checks.
`timescale 1ns/1ps
module tb_tt_memop_req_arb;
  import tt_memop_arb_pkg::*;

  localparam int ADDR_W = 64, DATA_W = 64, MAX_OUTST = 8, TAG_W = 3, TB_TIMEOUT = 16;
  localparam int OUT_W = $clog2(MAX_OUTST+1);
  localparam int W = 1 + ADDR_W + DATA_W + TAG_W;

  logic              i_clk, i_reset, i_sync_start, i_is_load, i_issue_done;
  logic              i_ld_valid, o_ld_ready, i_st_valid, o_st_ready;
  logic [ADDR_W-1:0] i_ld_addr, i_st_addr, o_mem_addr;
  logic [DATA_W-1:0] i_st_data, o_mem_data;
  logic              o_mem_valid, o_mem_we, i_mem_ready, i_resp_valid;
  logic [TAG_W-1:0]  o_mem_tag;
  logic              o_mem_req, o_sync_end, o_err;
  logic [OUT_W-1:0]  o_outst;
  arb_state_t        state;

  tt_memop_req_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST),
                     .TAG_W(TAG_W), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_sync_start(i_sync_start), .i_is_load(i_is_load),
    .i_issue_done(i_issue_done), .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr),
    .o_ld_ready(o_ld_ready), .i_st_valid(i_st_valid), .i_st_addr(i_st_addr),
    .i_st_data(i_st_data), .o_st_ready(o_st_ready), .o_mem_valid(o_mem_valid),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_tag(o_mem_tag), .i_mem_ready(i_mem_ready), .i_resp_valid(i_resp_valid),
    .o_mem_req(o_mem_req), .o_sync_end(o_sync_end), .o_outst(o_outst), .o_err(o_err),
    .o_state(state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  int               n_checks = 0, n_fail = 0, n_popped = 0, peak_outst = 0;
  logic [W-1:0]     exp_q[$];
  bit               grant_q[$];
  logic [TAG_W-1:0] exp_tag = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: push on accepted request, pop when the memory port takes one
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_mem_valid && i_mem_ready) begin
        logic [W-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : {W{1'bx}};
        check("sb_req", {o_mem_we, o_mem_addr, o_mem_data, o_mem_tag}, e);
        n_popped++;
      end
      if (i_ld_valid && o_ld_ready) begin
        exp_q.push_back({1'b0, i_ld_addr, {DATA_W{1'b0}}, exp_tag});
        grant_q.push_back(1'b0);
        exp_tag++;
      end
      if (i_st_valid && o_st_ready) begin
        exp_q.push_back({1'b1, i_st_addr, i_st_data, exp_tag});
        grant_q.push_back(1'b1);
        exp_tag++;
      end
      if (int'(o_outst) > peak_outst) peak_outst = int'(o_outst);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_sync_start = 0; i_is_load = 0; i_issue_done = 0; i_ld_valid = 0; i_st_valid = 0;
    i_mem_ready = 1; i_resp_valid = 0;
    repeat (2) cyc();
    i_reset = 1'b0;
    exp_q.delete(); grant_q.delete();
    exp_tag = '0; n_popped = 0; peak_outst = 0;
  endtask

  task automatic start(input logic ld);
    i_sync_start = 1'b1; i_is_load = ld;
    cyc();
    i_sync_start = 1'b0;
  endtask

  task automatic pulse_done();
    i_issue_done = 1'b1; cyc(); i_issue_done = 1'b0;
  endtask

  task automatic respond(input int n);
    for (int k = 0; k < n; k++) begin
      i_resp_valid = 1'b1; cyc();
    end
    i_resp_valid = 1'b0;
  endtask

  task automatic send_ld(input logic [ADDR_W-1:0] a);
    bit ok;
    ok = 0;
    i_ld_valid = 1'b1; i_ld_addr = a;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1; ok = o_ld_ready;
      cyc();
    end
    i_ld_valid = 1'b0;
    check("ld_accept", W'(ok), W'(1));
  endtask

  task automatic st_new();
    i_st_addr = {32'h5700_0000, $urandom_range(0, 32'hffff_fff0)};
    i_st_data = {$urandom(), $urandom()};
  endtask

  task automatic wait_state(input arb_state_t s, input string tag);
    int k;
    k = 0;
    while (state != s && k < 60) begin cyc(); k++; end
    check(tag, W'(state), W'(s));
  endtask

  int acc, n, seen_end;

  initial begin
    i_ld_addr = '0; i_st_addr = '0; i_st_data = '0;
    do_reset();
    // reset state, with both requesters valid so readies are meaningful
    i_reset = 1'b1; i_ld_valid = 1; i_st_valid = 1;
    cyc(); #1;
    check("rst_state", W'(state), W'(IDLE));
    check("rst_outs", W'({o_ld_ready, o_st_ready, o_mem_valid, o_mem_req, o_sync_end, o_err}), W'(0));
    check("rst_outst", W'(o_outst), W'(0));
    do_reset();

    // single load memop: three loads, tags 0..2, peak 3 in flight
    start(1'b1);
    check("ld_active", W'(state), W'(ACTIVE));
    for (int i = 0; i < 3; i++) send_ld(64'h1000_0000 + 64'(i * 8));
    pulse_done();
    repeat (5) cyc();
    check("ld_drain", W'(state), W'(DRAIN));
    check("ld_outst3", W'(o_outst), W'(3));
    check("ld_memreq", W'(o_mem_req), W'(1));
    respond(3);
    check("ld_end_early", W'({o_sync_end, o_outst}), W'(0));
    cyc();
    check("ld_sync_end", W'(o_sync_end), W'(1));
    cyc();
    check("ld_idle", W'({state, o_sync_end, o_mem_req, o_err}), W'({IDLE, 3'b000}));
    check("ld_count", W'(n_popped), W'(3));
    check("ld_peak", W'(peak_outst), W'(3));

    // credit limit on a store memop, responses withheld
    do_reset();
    start(1'b0);
    i_st_valid = 1'b1; st_new(); acc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (o_st_ready) begin acc++; cyc(); st_new(); end
      else cyc();
    end
    #1;
    check("cred_acc8", W'(acc), W'(8));
    check("cred_outst8", W'(o_outst), W'(8));
    check("cred_ready0", W'(o_st_ready), W'(0));
    for (int r = 0; r < 2; r++) begin
      respond(1); acc = 0;
      for (int k = 0; k < 6; k++) begin
        #1;
        if (o_st_ready) begin acc++; cyc(); st_new(); end
        else cyc();
      end
      check("cred_one_more", W'(acc), W'(1));
    end
    i_st_valid = 1'b0;
    repeat (2) cyc();
    respond(3);
    check("cred_outst5", W'(o_outst), W'(5));

    // backpressure: held request stays stable, nothing else accepted
    i_mem_ready = 1'b0; i_st_valid = 1'b1; st_new();
    #1; check("bp_accept", W'(o_st_ready), W'(1));
    begin
      logic [W-1:0] held;
      held = {1'b1, i_st_addr, i_st_data, TAG_W'(10)};
      cyc(); st_new();
      for (int k = 0; k < 4; k++) begin
        #1;
        check("bp_fields", {o_mem_valid, o_mem_addr, o_mem_data, o_mem_tag}, held);
        check("bp_no_accept", W'(o_st_ready), W'(0));
        cyc();
      end
    end
    // drain the held store, accept the waiting one and take a response together
    i_mem_ready = 1'b1; i_resp_valid = 1'b1;
    #1; check("sim_accept", W'(o_st_ready), W'(1));
    cyc();
    i_resp_valid = 1'b0; i_st_valid = 1'b0;
    check("sim_outst5", W'(o_outst), W'(5));
    pulse_done();
    respond(6);
    wait_state(END, "st_end");
    cyc();
    check("st_idle", W'({state, o_err}), W'({IDLE, 1'b0}));
    check("st_count", W'(n_popped), W'(12));
    check("st_q_empty", W'(exp_q.size()), W'(0));

    // spurious response in IDLE
    respond(1);
    check("spur_err", W'({o_err, o_outst}), W'({1'b1, {OUT_W{1'b0}}}));

    // both sides valid: strict alternation, error on first mismatched grant
    do_reset();
    start(1'b1);
    i_ld_valid = 1; i_st_valid = 1; i_ld_addr = 64'h2000; st_new(); n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      logic gl, gs;
      #1; gl = o_ld_ready; gs = o_st_ready;
      cyc();
      if (gl || gs) begin
        n++;
        if (n == 1) check("alt_err_after_ld", W'(o_err), W'(0));
        if (n == 2) check("alt_err_after_st", W'(o_err), W'(1));
        if (gl) i_ld_addr = i_ld_addr + 64'h40;
        if (gs) st_new();
      end
    end
    i_ld_valid = 0; i_st_valid = 0;
    check("alt_grants", W'(grant_q.size()), W'(4));
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check($sformatf("alt_side%0d", i), W'(grant_q[i]), W'(i % 2));
    pulse_done();
    wait_state(DRAIN, "rst_mid_drain");
    check("rst_mid_outst4", W'(o_outst), W'(4));
    i_reset = 1'b1;
    cyc();
    check("rst_mid_idle", W'({state, o_outst, o_sync_end, o_mem_valid, o_err}),
          W'({IDLE, {OUT_W{1'b0}}, 3'b000}));
    i_reset = 1'b0; seen_end = 0;
    for (int k = 0; k < 4; k++) begin cyc(); seen_end |= int'(o_sync_end); end
    check("rst_mid_no_end", W'(seen_end), W'(0));
    do_reset();

    // minimum start-to-end latency with no requests, then stray sync_start
    start(1'b1);
    check("lat_active", W'({state, o_mem_req}), W'({ACTIVE, 1'b1}));
    pulse_done();
    check("lat_drain", W'({state, o_sync_end}), W'({DRAIN, 1'b0}));
    cyc();
    check("lat_end", W'(o_sync_end), W'(1));
    cyc();
    check("lat_idle", W'({state, o_err}), W'({IDLE, 1'b0}));
    start(1'b0);
    start(1'b1);
    check("restart_err", W'({state, o_err}), W'({ACTIVE, 1'b1}));

`ifdef TT_MEMOP_ARB_TIMEOUT_EN
    // drain watchdog with a withheld response
    do_reset();
    start(1'b1);
    send_ld(64'h3000);
    pulse_done();
    wait_state(DRAIN, "wd_drain");
    n = 0;
    while (!o_sync_end && n < 40) begin cyc(); n++; end
    check("wd_cycles", W'(n), W'(TB_TIMEOUT));
    check("wd_err", W'({o_err, o_outst}), W'({1'b1, {OUT_W{1'b0}}}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
